// File: rtl/wdt_ctrl.sv
// wdt_ctrl: bus-mapped watchdog sequencing COUNT -> GRACE (irq) -> RESET pulse.
// Define WDT_WINDOW_EN to treat feeds above WINDOW as early (immediate reset).
module wdt_ctrl #(
    parameter int              CNT_W        = 16,
    parameter int              PRESCALE     = 4,
    parameter int              GRACE_CYCLES = 8,
    parameter int              RST_PULSE    = 4,
    parameter logic [CNT_W-1:0] DEFAULT_LOAD = 16'h0100,
    parameter logic [31:0]     FEED_KEY     = 32'h5A5AA5A5,
    parameter logic [CNT_W-1:0] WINDOW       = 16'h0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [2:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        wdt_irq,
    output logic        wdt_reset
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int GW = $clog2(GRACE_CYCLES + 1);
    localparam int RW = $clog2(RST_PULSE + 1);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    localparam logic [GW-1:0] GR_INIT = GW'(GRACE_CYCLES);
    localparam logic [RW-1:0] RP_INIT = RW'(RST_PULSE);

`ifdef WDT_WINDOW_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_GRACE, S_RESET} state_t;

    state_t           r_state;
    logic [2:0]       r_ctrl;
    logic [CNT_W-1:0] r_load;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_presc;
    logic [GW-1:0]    r_grace;
    logic [RW-1:0]    r_pulse;
    logic             r_pend;
    logic             r_bad;
    logic             r_early;
    logic             r_irq;
    logic             r_wrst;
    logic [31:0]      r_rdata;

    logic             w_wr_ctrl, w_wr_load, w_wr_feed, w_wr_stat;
    logic             w_locked, w_ctrl_ok, w_key_ok, w_feed_ok;
    logic             w_wrap, w_in_count, w_in_grace;
    logic             w_disable, w_early, w_expire, w_rescue;
    logic             w_rst_end, w_start;
    logic [2:0]       w_w1c, w_ctrl_nxt;
    logic             w_pend_nxt, w_bad_nxt, w_early_nxt;
    logic [CNT_W-1:0] w_load_eff;
    logic [31:0]      w_rdata;

    assign w_wr_ctrl = bus_we && (bus_addr == 3'd0);
    assign w_wr_load = bus_we && (bus_addr == 3'd1);
    assign w_wr_feed = bus_we && (bus_addr == 3'd2);
    assign w_wr_stat = bus_we && (bus_addr == 3'd3);

    assign w_locked   = r_ctrl[1];
    assign w_ctrl_ok  = w_wr_ctrl && !w_locked;
    assign w_key_ok   = (bus_wdata == FEED_KEY);
    assign w_feed_ok  = w_wr_feed && w_key_ok;
    assign w_load_eff = (r_load == '0) ? CNT_W'(1) : r_load;
    assign w_wrap     = (r_presc == PS_LAST);
    assign w_in_count = (r_state == S_COUNT);
    assign w_in_grace = (r_state == S_GRACE);

    // In COUNT: disable beats early feed beats valid feed beats expiry
    assign w_disable = w_in_count && w_ctrl_ok && !bus_wdata[0];
    assign w_early   = WIN_EN && w_in_count && w_feed_ok && !w_disable
                       && (r_cnt > WINDOW);
    assign w_expire  = w_in_count && !w_disable && !w_feed_ok && w_wrap
                       && (r_cnt <= CNT_W'(1));
    assign w_rescue  = w_in_grace && w_feed_ok;
    assign w_rst_end = (r_state == S_RESET) && (r_pulse <= RW'(1));
    assign w_start   = (r_state == S_IDLE) && w_ctrl_ok && bus_wdata[0];
    assign w_w1c     = w_wr_stat ? bus_wdata[2:0] : 3'b000;

    assign w_ctrl_nxt  = w_rst_end ? 3'b000
                       : (w_ctrl_ok ? bus_wdata[2:0] : r_ctrl);
    assign w_pend_nxt  = w_expire
                       | (r_pend & ~w_w1c[0] & ~w_rescue & ~w_rst_end);
    assign w_bad_nxt   = (w_wr_feed & ~w_key_ok) | (r_bad & ~w_w1c[1]);
    assign w_early_nxt = w_early | (r_early & ~w_w1c[2]);

    always_comb begin
        w_rdata = '0;
        case (bus_addr)
            3'd0:    w_rdata[2:0]       = r_ctrl;
            3'd1:    w_rdata[CNT_W-1:0] = r_load;
            3'd3:    w_rdata[2:0]       = {r_early, r_bad, r_pend};
            3'd4:    w_rdata[CNT_W-1:0] = r_cnt;
            default: w_rdata            = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ctrl  <= '0;
            r_load  <= DEFAULT_LOAD;
            r_cnt   <= '0;
            r_presc <= '0;
            r_grace <= '0;
            r_pulse <= '0;
            r_pend  <= 1'b0;
            r_bad   <= 1'b0;
            r_early <= 1'b0;
            r_irq   <= 1'b0;
            r_wrst  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ctrl  <= w_ctrl_nxt;
            r_pend  <= w_pend_nxt;
            r_bad   <= w_bad_nxt;
            r_early <= w_early_nxt;
            // irq tracks the post-edge pending/enable pair so it rises with IRQ_PEND
            r_irq   <= w_pend_nxt & w_ctrl_nxt[2];
            if (w_wr_load && !w_locked)
                r_load <= bus_wdata[CNT_W-1:0];
            if (bus_re)
                r_rdata <= w_rdata;
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_COUNT;
                        r_cnt   <= w_load_eff;
                        r_presc <= '0;
                    end
                end
                S_COUNT: begin
                    if (w_disable) begin
                        r_state <= S_IDLE;
                    end else if (w_early) begin
                        r_state <= S_RESET;
                        r_pulse <= RP_INIT;
                        r_wrst  <= 1'b1;
                    end else if (w_feed_ok) begin
                        r_cnt   <= w_load_eff;
                        r_presc <= '0;
                    end else if (w_wrap) begin
                        r_presc <= '0;
                        r_cnt   <= r_cnt - CNT_W'(1);
                        if (w_expire) begin
                            r_state <= S_GRACE;
                            r_grace <= GR_INIT;
                        end
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
                S_GRACE: begin
                    if (w_feed_ok) begin
                        r_state <= S_COUNT;
                        r_cnt   <= w_load_eff;
                        r_presc <= '0;
                    end else if (r_grace <= GW'(1)) begin
                        r_state <= S_RESET;
                        r_pulse <= RP_INIT;
                        r_wrst  <= 1'b1;
                    end else begin
                        r_grace <= r_grace - GW'(1);
                    end
                end
                S_RESET: begin
                    if (w_rst_end) begin
                        r_state <= S_IDLE;
                        r_wrst  <= 1'b0;
                    end else begin
                        r_pulse <= r_pulse - RW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus_rdata = r_rdata;
    assign wdt_irq   = r_irq;
    assign wdt_reset = r_wrst;

endmodule

// File: doc/wdt_ctrl.md
Name: wdt_ctrl

Overview:
Memory-mapped watchdog controller for the RV32I pipeline.
- Sits on the MEM-stage data bus next to data memory.
- Lets software configure, lock and feed the watchdog.
- Sequences the timeout: COUNT, then IRQ grace window, then reset pulse. The pulse drives the core-level wdt_irq and wdt_reset.

Parameters:
CNT_W, 16, width of timeout counter and LOAD register
PRESCALE, 4, clock cycles per counter decrement (>=1)
GRACE_CYCLES, 8, raw clock cycles between IRQ assertion and reset
RST_PULSE, 4, width in cycles of wdt_reset pulse
DEFAULT_LOAD, 16'h0100, reset value of LOAD
FEED_KEY, 32'h5A5AA5A5, magic value that feeds the watchdog
WINDOW, 16'h0040, window-open threshold (used only with WDT_WINDOW_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
bus_we  in  1  register write strobe (single cycle)
bus_re  in  1  register read strobe
bus_addr  in  3  word index: 0 CTRL, 1 LOAD, 2 FEED, 3 STATUS, 4 COUNT
bus_wdata  in  32  write data
bus_rdata  out  32  read data, registered
wdt_irq  out  1  watchdog interrupt, level
wdt_reset  out  1  processor reset request pulse

Behaviour:
Reset:
- All outputs 0; CTRL=0; LOAD=DEFAULT_LOAD; STATUS=0; counter=0; prescaler=0; state=IDLE.
- rst mid-sequence aborts immediately, including during a wdt_reset pulse.

Registers:
- CTRL: bit0 EN, bit1 LOCK (set-only; cleared only by rst or on leaving RESET), bit2 IRQ_EN.
- LOAD: bits [CNT_W-1:0]. A value of 0 is treated as 1.
- FEED: write-only. Writing FEED_KEY reloads counter=LOAD and prescaler=0. Any other value is ignored and sets STATUS.BAD_FEED.
- STATUS: bit0 IRQ_PEND (W1C), bit1 BAD_FEED (W1C).
- COUNT: read-only current counter value.
- LOCK=1: writes to CTRL and LOAD are ignored; EN cannot be cleared.
- Reads: bus_rdata is updated on the edge after bus_re; it holds its value otherwise. Unmapped addresses read 0; writes to them are ignored.

FSM:
- IDLE: counter frozen. A write setting EN goes to COUNT with counter=LOAD, prescaler=0.
- COUNT: prescaler counts 0..PRESCALE-1; each wrap decrements the counter. A decrement that produces 0 goes to GRACE, sets IRQ_PEND, and loads the grace counter with GRACE_CYCLES. Clearing EN (unlocked) returns to IDLE.
- GRACE: grace counter decrements every clock. A valid feed reloads, clears IRQ_PEND and returns to COUNT. Grace counter reaching 0 goes to RESET.
- RESET: wdt_reset=1 for exactly RST_PULSE cycles, then IDLE. On exit CTRL is cleared to 0 and IRQ_PEND to 0; LOAD is kept.

Outputs and timing:
- wdt_irq = IRQ_PEND & IRQ_EN, registered. Writing 1 to IRQ_PEND clears it; the FSM stays in GRACE.
- Latency: wdt_irq rises LOAD*PRESCALE cycles after the EN write edge (no feeds). wdt_reset rises GRACE_CYCLES cycles later.

Simultaneous events:
- A feed in the same cycle as the decrement to 0 wins: reload, no IRQ.
- A W1C to IRQ_PEND in the same cycle it is set leaves it set.
- Feed writes in IDLE or RESET are ignored; BAD_FEED is still flagged for a wrong key.
- A LOAD write in COUNT takes effect at the next reload only.

Optional Feature:
WDT_WINDOW_EN:
- When defined, a valid feed in COUNT while counter > WINDOW is an early feed. It sets STATUS bit2 EARLY and goes directly to RESET.
- Feeds at counter <= WINDOW, or in GRACE, behave normally.
- When undefined, feeds are accepted at any counter value and STATUS bit2 reads 0.

Test Plan:
Basic timeout:
- Stimulus: LOAD=10, CTRL=0x5 (EN, IRQ_EN), no feeds.
- Expected: wdt_irq=1 at 40 cycles after the EN write. wdt_reset=1 at 48 cycles, held 4 cycles. CTRL reads 0 afterwards.

Feeding:
- Stimulus: LOAD=10, EN=1, FEED=0x5A5AA5A5 every 30 cycles for 300 cycles.
- Expected: wdt_irq and wdt_reset stay 0; COUNT never below 2.

Bad key and lock:
- Stimulus: LOCK set, then CTRL=0 written, then FEED=0x12345678.
- Expected: EN remains 1; BAD_FEED=1; timeout still fires at cycle 40.

Grace rescue:
- Stimulus: let IRQ assert, valid feed 3 cycles later.
- Expected: IRQ_PEND=0, wdt_irq=0, wdt_reset never asserts, state back to COUNT with COUNT=10.

Reset mid-pulse plus race:
- Stimulus: assert rst during the 2nd wdt_reset cycle.
- Expected: wdt_reset=0 immediately, all registers at reset values.
- Stimulus: feed on the cycle COUNT goes 1 to 0.
- Expected: no IRQ.

Window (WDT_WINDOW_EN, LOAD=0x100, WINDOW=0x40):
- Stimulus: feed at COUNT=0x80.
- Expected: EARLY=1, wdt_reset pulse.
- Stimulus: feed at COUNT=0x30.
- Expected: normal reload.
